// File: rtl/turn_timer_pkg.sv
// Shared constants for the turn deadline timer: state encoding and default widths,
// also used by the blackjack controller when sizing its timeout constants.
package turn_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    EXPIRE = 2'd3
  } state_t;

  localparam int DEF_TIME_W = 32;
  localparam int DEF_DUR_W  = 16;

endpackage

// File: rtl/turn_timer.sv
// Per-turn deadline timer driven by the free-running time_ms count.
// Optional low-time warning output enabled by defining TURN_TIMER_WARN_EN.
module turn_timer
  import turn_timer_pkg::*;
#(
  parameter int TIME_W      = DEF_TIME_W,
  parameter int DUR_W       = DEF_DUR_W,
  parameter int WARN_THRESH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] time_ms,
  input  logic              start,
  input  logic [DUR_W-1:0]  duration,
  input  logic              pause,
  input  logic              cancel,
  output logic              busy,
  output logic              expired,
  output logic [DUR_W-1:0]  remaining,
  output logic              warn
);

  state_t            state, state_nxt;
  logic [TIME_W-1:0] start_ts, ts_nxt;
  logic [DUR_W-1:0]  dur_q, dur_nxt;
  logic [DUR_W-1:0]  held_q, held_nxt;
  logic [TIME_W-1:0] elapsed, elapsed_nxt;
  logic              timeout;
  logic [DUR_W-1:0]  left_now;
  logic [DUR_W-1:0]  rem_nxt;
  logic              busy_nxt;
  logic              expired_nxt;

  // Modulo subtraction makes time_ms wrap transparent; compare at full width.
  assign elapsed  = time_ms - start_ts;
  assign timeout  = (elapsed >= TIME_W'(dur_q));
  assign left_now = timeout ? '0 : DUR_W'(TIME_W'(dur_q) - elapsed);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      start_ts  <= '0;
      dur_q     <= '0;
      held_q    <= '0;
      busy      <= 1'b0;
      expired   <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      start_ts  <= ts_nxt;
      dur_q     <= dur_nxt;
      held_q    <= held_nxt;
      busy      <= busy_nxt;
      expired   <= expired_nxt;
      remaining <= rem_nxt;
    end
  end

  // Command priority is cancel, then start, then the timeout/pause handling.
  always_comb begin
    state_nxt = state;
    ts_nxt    = start_ts;
    dur_nxt   = dur_q;
    held_nxt  = held_q;
    if (cancel) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = RUN;
      ts_nxt    = time_ms;
      dur_nxt   = duration;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        RUN: begin
          if (timeout) begin
            state_nxt = EXPIRE;
          end else if (pause) begin
            state_nxt = HOLD;
            held_nxt  = left_now;
          end
        end
        HOLD: begin
          if (!pause) begin
            state_nxt = RUN;
            ts_nxt    = time_ms;
            dur_nxt   = held_q;
          end
        end
        EXPIRE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are computed from the next-state values and registered above.
  assign elapsed_nxt = time_ms - ts_nxt;

  always_comb begin
    busy_nxt    = (state_nxt == RUN) || (state_nxt == HOLD);
    expired_nxt = (state_nxt == EXPIRE);
    rem_nxt     = '0;
    case (state_nxt)
      RUN: begin
        if (elapsed_nxt < TIME_W'(dur_nxt))
          rem_nxt = DUR_W'(TIME_W'(dur_nxt) - elapsed_nxt);
      end
      HOLD:    rem_nxt = held_nxt;
      default: rem_nxt = '0;
    endcase
  end

`ifdef TURN_TIMER_WARN_EN
  logic warn_nxt;

  always_comb begin
    warn_nxt = (state_nxt == RUN) && (rem_nxt != '0) &&
               (rem_nxt <= DUR_W'(WARN_THRESH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      warn <= 1'b0;
    else
      warn <= warn_nxt;
  end
`else
  assign warn = 1'b0;
`endif

endmodule
